// File: rtl/conv_requant_pool.sv
// Post-convolution stage: bias + ReLU + rounded shift with 8-bit saturation, then 2x2/stride-2 max-pool.
// Define CONV_POOL_EN to build the max-pool; otherwise every requantized sample is output directly.
module conv_requant_pool #(
   parameter int Out_Dim = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   input  logic [15:0] bias,
   input  logic [3:0]  shift,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        frame_done
);
   // Valid-only streaming: a beat transfers whenever in_valid is high and there is no backpressure;
   // out_valid marks each output for exactly one cycle and out_data holds between strobes.
   localparam int CW = $clog2(Out_Dim);
   localparam logic [CW-1:0] POS_LAST = CW'(Out_Dim - 1);

   logic [CW-1:0] col_q, col_d, row_q, row_d;
   logic [CW-1:0] s1_col_q, s1_col_d, s1_row_q, s1_row_d;
   logic [7:0]    s1_data_q, s1_data_d;
   logic          s1_valid_q, s1_valid_d;

   logic signed [17:0] sum;
   logic [17:0]        relu, round_add, rnd, quo;
   logic [7:0]         sat;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (in_valid) begin
         if (col_q == POS_LAST) begin
            col_d = '0;
            row_d = (row_q == POS_LAST) ? '0 : row_q + CW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // 18-bit signed sum cannot overflow: 65535 + 32767 and the rounding term stay below 2^17.
   always_comb begin
      sum       = $signed({2'b00, in_data}) + $signed({{2{bias[15]}}, bias});
      relu      = sum[17] ? 18'd0 : 18'(sum);
      round_add = (shift == 4'd0) ? 18'd0 : (18'd1 << (shift - 4'd1));
      rnd       = relu + round_add;
      quo       = rnd >> shift;
      sat       = (quo > 18'd255) ? 8'hFF : quo[7:0];
   end

   always_comb begin
      s1_valid_d = in_valid;
      s1_data_d  = in_valid ? sat   : s1_data_q;
      s1_col_d   = in_valid ? col_q : s1_col_q;
      s1_row_d   = in_valid ? row_q : s1_row_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q      <= '0;
         row_q      <= '0;
         s1_col_q   <= '0;
         s1_row_q   <= '0;
         s1_data_q  <= '0;
         s1_valid_q <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         s1_col_q   <= s1_col_d;
         s1_row_q   <= s1_row_d;
         s1_data_q  <= s1_data_d;
         s1_valid_q <= s1_valid_d;
      end
   end

`ifdef CONV_POOL_EN
   localparam int HALF = Out_Dim / 2;
   localparam int LBW  = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] WIN_LAST = CW'(2 * HALF - 1);
   localparam bit ODD_DIM = (Out_Dim % 2) == 1;

   function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [7:0]     pair_max_q, pair_max_d;
   logic [7:0]     out_data_q, out_data_d;
   logic           out_valid_q, out_valid_d;
   logic           frame_done_q, frame_done_d;
   logic [7:0]     linebuf_q [2**LBW];
   logic           lb_we;
   logic [LBW-1:0] lb_addr;
   logic [7:0]     lb_wdata, lb_rdata;
   logic           in_win;

   assign lb_addr  = LBW'(s1_col_q >> 1);
   assign lb_rdata = linebuf_q[lb_addr];

   // With an odd size the trailing column and row never belong to a window.
   always_comb begin
      in_win       = !ODD_DIM || ((s1_col_q != POS_LAST) && (s1_row_q != POS_LAST));
      pair_max_d   = pair_max_q;
      out_data_d   = out_data_q;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      lb_we        = 1'b0;
      lb_wdata     = '0;
      if (s1_valid_q && in_win) begin
         if (!s1_col_q[0]) begin
            pair_max_d = s1_data_q;
         end else if (!s1_row_q[0]) begin
            lb_we    = 1'b1;
            lb_wdata = max8(pair_max_q, s1_data_q);
         end else begin
            out_valid_d  = 1'b1;
            out_data_d   = max8(lb_rdata, max8(pair_max_q, s1_data_q));
            frame_done_d = (s1_col_q == WIN_LAST) && (s1_row_q == WIN_LAST);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pair_max_q   <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         pair_max_q   <= pair_max_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Every entry is written on an even row before the odd row reads it, so no reset is needed.
   always_ff @(posedge clk) begin
      if (lb_we) linebuf_q[lb_addr] <= lb_wdata;
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;
`else
   assign out_data   = s1_data_q;
   assign out_valid  = s1_valid_q;
   assign frame_done = s1_valid_q && (s1_col_q == POS_LAST) && (s1_row_q == POS_LAST);
`endif

endmodule

// File: tb/tb_conv_requant_pool.sv
// Directed bench for conv_requant_pool: a 4x4 instance and a 3x3 instance, with a queue scoreboard
// holding hand-computed outputs and their due cycles; follows the CONV_POOL_EN build option.
module tb_conv_requant_pool;
`ifdef CONV_POOL_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        rst;
   logic [15:0] in_data;
   logic        va, vb;
   logic [15:0] bias;
   logic [3:0]  shift;
   logic [7:0]  oda, odb;
   logic        ova, ovb, fda, fdb;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   logic [8:0] exp_q_a[$];
   logic [8:0] exp_q_b[$];
   int         due_q_a[$];
   int         due_q_b[$];
   logic [8:0] ea, eb;
   int         da, db;

   conv_requant_pool #(.Out_Dim(4)) dut_a (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(va), .bias(bias), .shift(shift),
      .out_data(oda), .out_valid(ova), .frame_done(fda)
   );

   conv_requant_pool #(.Out_Dim(3)) dut_b (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vb), .bias(bias), .shift(shift),
      .out_data(odb), .out_valid(ovb), .frame_done(fdb)
   );

   // clock / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // driver tasks
   task automatic beat(input bit sel_b, input int d, input bit exp, input int ev, input bit efd);
      @(posedge clk);
      #1;
      in_data = 16'(d);
      va      = !sel_b;
      vb      = sel_b;
      if (exp) begin
         if (sel_b) begin
            exp_q_b.push_back({efd, 8'(ev)});
            due_q_b.push_back(cyc + LAT);
         end else begin
            exp_q_a.push_back({efd, 8'(ev)});
            due_q_a.push_back(cyc + LAT);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         va = 1'b0;
         vb = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      va  = 1'b0;
      vb  = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_a_valid", ova, 0);
      chk("rst_a_data", oda, 0);
      chk("rst_a_done", fda, 0);
      chk("rst_b_valid", ovb, 0);
      chk("rst_b_data", odb, 0);
      chk("rst_b_done", fdb, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // 4x4 frame of 0..15 with bias 0 / shift 0: the pool emits 5,7,13,15, bypass echoes each sample.
   task automatic frame4(input bit gap);
      bit e;
      for (int i = 0; i < 16; i++) begin
`ifdef CONV_POOL_EN
         e = ((i / 4) % 2 == 1) && (i % 2 == 1);
`else
         e = 1'b1;
`endif
         beat(1'b0, i, e, i, i == 15);
         if (gap) idle(1);
      end
   endtask

   // 3x3 frame of 0..8: the pool emits only max(0,1,3,4)=4; bypass echoes each sample.
   task automatic frame3();
      for (int i = 0; i < 9; i++) begin
`ifdef CONV_POOL_EN
         beat(1'b1, i, i == 4, 4, 1'b1);
`else
         beat(1'b1, i, 1'b1, i, i == 8);
`endif
      end
   endtask

   // scoreboard monitors
   always @(negedge clk) begin
      if (ova === 1'b1) begin
         if (exp_q_a.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL a_spurious: out_data %0d with nothing expected (cycle %0d)", oda, cyc);
         end else begin
            ea = exp_q_a.pop_front();
            da = due_q_a.pop_front();
            chk("a_data", oda, ea[7:0]);
            chk("a_frame_done", fda, ea[8]);
            chk("a_latency", cyc, da);
         end
      end else if (fda === 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL a_stray_done: frame_done 1 without out_valid, required 0 (cycle %0d)", cyc);
      end
   end

   always @(negedge clk) begin
      if (ovb === 1'b1) begin
         if (exp_q_b.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL b_spurious: out_data %0d with nothing expected (cycle %0d)", odb, cyc);
         end else begin
            eb = exp_q_b.pop_front();
            db = due_q_b.pop_front();
            chk("b_data", odb, eb[7:0]);
            chk("b_frame_done", fdb, eb[8]);
            chk("b_latency", cyc, db);
         end
      end else if (fdb === 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL b_stray_done: frame_done 1 without out_valid, required 0 (cycle %0d)", cyc);
      end
   end

   initial begin
      rst     = 1'b1;
      va      = 1'b0;
      vb      = 1'b0;
      in_data = '0;
      bias    = '0;
      shift   = '0;
      do_reset();

`ifndef CONV_POOL_EN
      // rounding and saturation: (x+2)>>2 -> 3, 250, 275->255, 16384->255
      shift = 4'd2;
      beat(1'b0, 10, 1'b1, 3, 1'b0);
      beat(1'b0, 1000, 1'b1, 250, 1'b0);
      beat(1'b0, 1100, 1'b1, 255, 1'b0);
      beat(1'b0, 65535, 1'b1, 255, 1'b0);
      idle(1);
      // ReLU with bias -20, then +10 on 65530 must saturate rather than wrap
      shift = 4'd0;
      bias  = 16'hFFEC;
      beat(1'b0, 5, 1'b1, 0, 1'b0);
      beat(1'b0, 20, 1'b1, 0, 1'b0);
      beat(1'b0, 300, 1'b1, 255, 1'b0);
      idle(1);
      bias = 16'd10;
      beat(1'b0, 65530, 1'b1, 255, 1'b0);
      idle(2);
      bias = 16'd0;
      do_reset();
`endif

      bias  = 16'd0;
      shift = 4'd0;
      frame4(1'b0);
      frame4(1'b1);
      idle(3);

      // reset after 6 beats; the partial frame's sixth beat must never produce output
      for (int i = 0; i < 6; i++) begin
`ifdef CONV_POOL_EN
         beat(1'b0, i, 1'b0, 0, 1'b0);
`else
         beat(1'b0, i, i < 5, i, 1'b0);
`endif
      end
      do_reset();
      frame4(1'b0);
      idle(3);

      frame3();
      frame3();
      idle(4);

      for (int t = 0; t < 50 && (exp_q_a.size() + exp_q_b.size()) > 0; t++) @(posedge clk);
      while (exp_q_a.size() > 0) begin
         ea = exp_q_a.pop_front();
         void'(due_q_a.pop_front());
         n_vec++;
         n_err++;
         $display("FAIL a_missing: no output, required out_data %0d", ea[7:0]);
      end
      while (exp_q_b.size() > 0) begin
         eb = exp_q_b.pop_front();
         void'(due_q_b.pop_front());
         n_vec++;
         n_err++;
         $display("FAIL b_missing: no output, required out_data %0d", eb[7:0]);
      end

      @(negedge clk);
      chk("a_hold", oda, 15);
`ifdef CONV_POOL_EN
      chk("b_hold", odb, 4);
`else
      chk("b_hold", odb, 8);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
